// File: rtl/fifo_256_unpack_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_256_unpack_if
// Description : Output segment stream of the 256-bit FIFO unpacker.
//               master : drives m_data / m_valid / m_last, samples m_ready
//               slave  : samples m_data / m_valid / m_last, drives m_ready
//   m_data   SEG_W  output segment
//   m_valid  1      m_data valid
//   m_ready  1      downstream accept
//   m_last   1      high with the final segment of a 256-bit word
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_256_unpack_if #(
  parameter int SEG_W = 32
) ();
  logic [SEG_W-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );
endinterface
`default_nettype wire

// File: rtl/fifo_256_unpack.sv
`default_nettype none
// ============================================================================
// Module      : fifo_256_unpack
// Description : Read-side engine for a standard-read (non-FWFT, 1-cycle read
//               latency) 256-bit FIFO. Pops one word at a time, prefetches it
//               into a holding register and serialises it LSB segment first
//               onto a valid/ready stream of SEG_W-bit segments.
// Parameters  : SEG_W - segment width, must divide 256 with 256/SEG_W >= 2
//               CNT_W - width of the emitted-word counter
// Ports       : clk, rst_n (async, active low), flush (sync drop of all
//               buffered / in-flight data)
//               fifo_dout / fifo_empty / fifo_rd_en - FIFO read side
//               m_if (master) - segment stream
//               words_out - count of fully emitted words (wraps)
//               busy      - read in flight or any data buffered
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_256_unpack #(
  parameter int SEG_W = 32,
  parameter int CNT_W = 16
) (
  input  wire                clk,
  input  wire                rst_n,
  input  wire                flush,
  input  wire  [255:0]       fifo_dout,
  input  wire                fifo_empty,
  output logic               fifo_rd_en,
  fifo_256_unpack_if.master  m_if,
  output logic [CNT_W-1:0]   words_out,
  output logic               busy
);

  localparam int NSEG  = 256 / SEG_W;
  localparam int IDX_W = $clog2(NSEG);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t             r_state;
  logic               r_pend;       // pop issued last cycle, data arrives now
  logic               r_pre_vld;
  logic [255:0]       r_pre;        // prefetch holding register
  logic [255:0]       r_sh;         // word currently being serialised
  logic [IDX_W-1:0]   r_idx;
  logic [CNT_W-1:0]   r_words_out;

  logic [SEG_W-1:0]   w_seg [NSEG];
  logic               w_seg_last;
  logic               w_accept;
  logic               w_load;

  for (genvar g = 0; g < NSEG; g++) begin : g_seg
    assign w_seg[g] = r_sh[g*SEG_W +: SEG_W];
  end

  // Only one pop may be outstanding and it needs a free prefetch slot.
  assign fifo_rd_en = !fifo_empty && !r_pend && !r_pre_vld && !flush;

  assign w_seg_last = (r_idx == IDX_W'(NSEG - 1));
  assign w_accept   = (r_state == ST_SEND) && m_if.m_ready;
  // Load the prefetched word when idle, or on the final accept of the current
  // word so back-to-back words stream without a bubble.
  assign w_load     = r_pre_vld &&
                      ((r_state == ST_EMPTY) || (w_accept && w_seg_last));

  assign m_if.m_valid = (r_state == ST_SEND);
  assign m_if.m_data  = w_seg[r_idx];
  assign m_if.m_last  = (r_state == ST_SEND) && w_seg_last;
  assign words_out    = r_words_out;
  assign busy         = r_pend || r_pre_vld || (r_state == ST_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_EMPTY;
      r_pend      <= 1'b0;
      r_pre_vld   <= 1'b0;
      r_pre       <= '0;
      r_sh        <= '0;
      r_idx       <= '0;
      r_words_out <= '0;
    end else begin
      r_pend <= fifo_rd_en;
      if (flush) begin
        // Any capture due from a pop in flight is dropped here as well.
        r_pre_vld <= 1'b0;
        r_state   <= ST_EMPTY;
        r_idx     <= '0;
      end else begin
        if (w_accept) begin
          r_idx <= r_idx + 1'b1;
          if (w_seg_last) begin
            r_idx       <= '0;
            r_words_out <= r_words_out + 1'b1;
            r_state     <= ST_EMPTY;
          end
        end
        if (w_load) begin
          r_sh    <= r_pre;
          r_idx   <= '0;
          r_state <= ST_SEND;
        end
        // A capture on the same edge as a load keeps the slot occupied.
        if (r_pend) begin
          r_pre     <= fifo_dout;
          r_pre_vld <= 1'b1;
        end else if (w_load) begin
          r_pre_vld <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_256_unpack.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_256_unpack
// Description : Self-checking bench for fifo_256_unpack (SEG_W=32, CNT_W=4).
//               A queue-based FIFO model feeds the DUT; every pushed word is
//               split into expected segments on a scoreboard queue that an
//               independent monitor drains on each accepted segment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_256_unpack;

  localparam int SEG_W = 32;
  localparam int NSEG  = 256 / SEG_W;
  localparam int CNT_W = 4;

  logic             clk        = 1'b0;
  logic             rst_n      = 1'b0;
  logic             flush      = 1'b0;
  logic             fifo_empty = 1'b1;
  logic [255:0]     fifo_dout  = '0;
  logic             fifo_rd_en;
  logic [CNT_W-1:0] words_out;
  logic             busy;

  fifo_256_unpack_if #(.SEG_W(SEG_W)) s_if ();

  fifo_256_unpack #(
    .SEG_W (SEG_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .m_if       (s_if.master),
    .words_out  (words_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [255:0]   fifo_q [$];
  logic [SEG_W:0] exp_q  [$];   // {last, data}
  int             exp_words = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- FIFO model: standard read, data one cycle after rd_en
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      checks++;
      if (fifo_q.size() == 0) begin
        failures++;
        $display("FAIL pop_on_empty: rd_en=1 with 0 words at %0t", $time);
      end else begin
        fifo_dout <= fifo_q.pop_front();
      end
    end
    #1;
    fifo_empty = (fifo_q.size() == 0);
  end

  // ---------------- Monitor / scoreboard
  logic             prev_stall = 1'b0;
  logic [SEG_W-1:0] prev_data  = '0;
  logic             prev_last  = 1'b0;

  always @(negedge clk) begin
    logic [SEG_W:0]   e;
    logic [CNT_W-1:0] ew;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      ew = exp_words[CNT_W-1:0];
      chk("words_out", words_out, ew);
      if (prev_stall) begin
        chk("stall_valid", s_if.m_valid, 1'b1);
        chk("stall_data",  s_if.m_data,  prev_data);
        chk("stall_last",  s_if.m_last,  prev_last);
      end
      if (s_if.m_valid && s_if.m_ready && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL extra_segment: got 0x%0h expected none at %0t", s_if.m_data, $time);
        end else begin
          e = exp_q.pop_front();
          chk("seg_data", s_if.m_data, e[SEG_W-1:0]);
          chk("seg_last", s_if.m_last, e[SEG_W]);
          if (e[SEG_W]) exp_words++;
        end
      end
      prev_stall = s_if.m_valid && !s_if.m_ready && !flush;
      prev_data  = s_if.m_data;
      prev_last  = s_if.m_last;
    end
  end

  // ---------------- Stimulus helpers
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_word(input logic [255:0] w);
    logic [SEG_W:0] e;
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    for (int k = 0; k < NSEG; k++) begin
      e = {(k == NSEG - 1), w[k*SEG_W +: SEG_W]};
      exp_q.push_back(e);
    end
  endtask

  function automatic logic [255:0] rnd_word();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic wait_idle(input string nm, input int max);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && fifo_q.size() == 0 && !busy) && n < max) begin
      step();
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s: idle not reached, %0d segs pending expected 0", nm, exp_q.size());
    end
  endtask

  task automatic wait_valid(input string nm, input int max);
    int n;
    n = 0;
    while (!s_if.m_valid && n < max) begin
      step();
      n++;
    end
    checks++;
    if (n >= max) begin
      failures++;
      $display("FAIL %s: m_valid=0 after %0d cycles expected 1", nm, max);
    end
  endtask

  // ---------------- Test sequence
  initial begin
    logic [255:0] w;
    logic [3:0]   pat;
    int nrd, nval, first_c, last_c;

    s_if.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", s_if.m_valid, 1'b0);
    chk("rst_last",  s_if.m_last,  1'b0);
    chk("rst_data",  s_if.m_data,  '0);
    chk("rst_words", words_out,    '0);
    chk("rst_busy",  busy,         1'b0);
    chk("rst_rd_en", fifo_rd_en,   1'b0);
    rst_n = 1'b1;
    step();

    // Single known word: latency and LSB-first order
    for (int b = 0; b < 32; b++) w[b*8 +: 8] = 8'(b + 1);
    s_if.m_ready = 1'b1;
    push_word(w);
    @(negedge clk);
    chk("t1_rd_en_c0", fifo_rd_en, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_c%0d", c), s_if.m_valid, (c == 3));
    end
    chk("t1_first_seg", s_if.m_data, 32'h0403_0201);
    wait_idle("t1_idle", 40);
    chk("t1_words", words_out, 4'd1);

    // Four queued words stream back-to-back
    step();
    for (int i = 0; i < 4; i++) push_word(rnd_word());
    nrd = 0; nval = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (s_if.m_valid) begin
        nval++;
        if (first_c < 0) first_c = c;
        last_c = c;
      end
    end
    chk("t2_rd_pulses", nrd, 4);
    chk("t2_valid_cycles", nval, 32);
    chk("t2_no_bubble_span", last_c - first_c + 1, 32);
    wait_idle("t2_idle", 20);
    chk("t2_words", words_out, 4'd5);

    // Backpressure 1,0,0,1
    step();
    push_word(rnd_word());
    push_word(rnd_word());
    pat = 4'b1001;
    for (int c = 0; c < 80; c++) begin
      s_if.m_ready = pat[c % 4];
      step();
    end
    s_if.m_ready = 1'b1;
    wait_idle("t3_idle", 40);
    chk("t3_words", words_out, 4'd7);

    // Flush with a pop in flight and a word mid-serialisation
    step();
    push_word(rnd_word());
    wait_valid("t4_first_valid", 10);
    step(); step(); step();
    s_if.m_ready = 1'b0;
    push_word(rnd_word());
    step();
    chk("t4_busy_before", busy, 1'b1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_valid_after", s_if.m_valid, 1'b0);
    chk("t4_busy_after",  busy,         1'b0);
    chk("t4_words",       words_out,    4'd7);
    nval = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (s_if.m_valid) nval++;
    end
    chk("t4_dropped_word", nval, 0);
    s_if.m_ready = 1'b1;

    // Randomised traffic and backpressure
    step();
    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 3) == 0 && fifo_q.size() < 3) push_word(rnd_word());
      s_if.m_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    s_if.m_ready = 1'b1;
    wait_idle("t5_idle", 100);

    // Asynchronous reset mid-word
    step();
    push_word(rnd_word());
    wait_valid("t6_valid", 10);
    step(); step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6_valid", s_if.m_valid, 1'b0);
    chk("t6_last",  s_if.m_last,  1'b0);
    chk("t6_data",  s_if.m_data,  '0);
    chk("t6_words", words_out,    '0);
    chk("t6_busy",  busy,         1'b0);
    chk("t6_rd_en", fifo_rd_en,   1'b0);
    exp_q.delete();
    exp_words = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Counter wrap: 17 words into a 4-bit counter
    for (int i = 0; i < 17; i++) push_word(rnd_word());
    wait_idle("t7_idle", 17 * NSEG + 60);
    chk("t7_words_wrap", words_out, 4'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
